// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - sixteen-entry register file with two registered read ports
//
// Stores one WIDTH-bit word per register. The write select comes from the
// write decoder as a one-hot 16-bit wordline, and two independent read ports
// return data one cycle after the index is presented. A read of the register
// being written in the same cycle returns the new value. A per-register
// written flag reports whether a register has been loaded since reset, and a
// sticky flag records any multi-hot wordline.
//
// Parameters:
//   WIDTH     - data width of each register and of both read ports
//   ZERO_REG  - 1: register 0 always reads as zero with valid set, and
//               writes to it are discarded
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   reset      in   synchronous, active-high
//   Wordline   in   one-hot write select; all-zero means no write
//   writeData  in   data written to the selected register
//   readA      in   read port A index
//   readB      in   read port B index
//   dataA      out  registered read data, port A
//   dataB      out  registered read data, port B
//   validA     out  register read on port A has been written since reset
//   validB     out  register read on port B has been written since reset
//   wlError    out  sticky; set after a multi-hot wordline is sampled
module reg_bank #(
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      Wordline,
    input  logic [WIDTH-1:0] writeData,
    input  logic [3:0]       readA,
    input  logic [3:0]       readB,
    output logic [WIDTH-1:0] dataA,
    output logic [WIDTH-1:0] dataB,
    output logic             validA,
    output logic             validB,
    output logic             wlError
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_q [16];
    logic [WIDTH-1:0] r_d [16];
    logic [15:0]      written_q;
    logic [15:0]      written_d;
    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic             wl_error_q, wl_error_d;

    // Clearing the lowest set bit leaves something only when two or more
    // bits were set; that distinguishes legal one-hot from illegal multi-hot.
    logic wl_any;
    logic wl_multi;
    logic wl_legal;

    assign wl_any   = (Wordline != 16'd0);
    assign wl_multi = ((Wordline & (Wordline - 16'd1)) != 16'd0);
    assign wl_legal = wl_any && !wl_multi;

    // Per-register write enable; register 0 is excluded when hardwired.
    logic [15:0] we;

    always_comb begin
        we = 16'd0;
        for (int i = 0; i < 16; i++) begin
            we[i] = wl_legal && Wordline[i] && !(ZR && (i == 0));
        end
    end

    always_comb begin
        written_d = written_q | we;
        for (int i = 0; i < 16; i++) begin
            r_d[i] = we[i] ? writeData : r_q[i];
        end
        wl_error_d = wl_error_q | wl_multi;
    end

    // Read sources. Forwarding uses the write enable rather than the raw
    // wordline, so a discarded write to the hardwired register never forwards
    // and a multi-hot wordline never forwards.
    always_comb begin
        if (ZR && (readA == 4'd0)) begin
            data_a_d  = '0;
            valid_a_d = 1'b1;
        end else if (we[readA]) begin
            data_a_d  = writeData;
            valid_a_d = 1'b1;
        end else begin
            data_a_d  = r_q[readA];
            valid_a_d = written_q[readA];
        end
    end

    always_comb begin
        if (ZR && (readB == 4'd0)) begin
            data_b_d  = '0;
            valid_b_d = 1'b1;
        end else if (we[readB]) begin
            data_b_d  = writeData;
            valid_b_d = 1'b1;
        end else begin
            data_b_d  = r_q[readB];
            valid_b_d = written_q[readB];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= '0;
            end
            written_q  <= 16'd0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            wl_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= r_d[i];
            end
            written_q  <= written_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            wl_error_q <= wl_error_d;
        end
    end

    assign dataA   = data_a_q;
    assign dataB   = data_b_q;
    assign validA  = valid_a_q;
    assign validB  = valid_b_q;
    assign wlError = wl_error_q;

endmodule
